// File: rtl/sram_arbiter.sv
// Two-master sram-like arbiter (fetch + load/store) onto one memory port, with an in-order owner FIFO for response routing.
// Optional macro SRAM_ARB_RR_EN switches the idle grant from fixed data priority to round-robin.
module sram_arbiter #(
    parameter int OST_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       inst_req,
    input  logic                       inst_wr,
    input  logic [1:0]                 inst_size,
    input  logic [3:0]                 inst_wstrb,
    input  logic [31:0]                inst_addr,
    input  logic [31:0]                inst_wdata,
    output logic                       inst_addr_ok,
    output logic                       inst_data_ok,
    output logic [31:0]                inst_rdata,

    input  logic                       data_req,
    input  logic                       data_wr,
    input  logic [1:0]                 data_size,
    input  logic [3:0]                 data_wstrb,
    input  logic [31:0]                data_addr,
    input  logic [31:0]                data_wdata,
    output logic                       data_addr_ok,
    output logic                       data_data_ok,
    output logic [31:0]                data_rdata,

    output logic                       mem_req,
    output logic                       mem_wr,
    output logic [1:0]                 mem_size,
    output logic [3:0]                 mem_wstrb,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_addr_ok,
    input  logic                       mem_data_ok,
    input  logic [31:0]                mem_rdata,

    output logic [$clog2(OST_DEPTH):0] ost_cnt,
    output logic                       arb_err
);

    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(OST_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOCK_I = 2'd1;
    localparam logic [1:0] LOCK_D = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 idle_grant;
    logic                 grant_d;
    logic                 granted_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 head_owner;
    logic [OST_DEPTH-1:0] owner_mem;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       cnt;

`ifdef SRAM_ARB_RR_EN
    logic                 last_data;

    // With both requesting, serve whoever did not win the previous handshake.
    assign idle_grant = data_req && (!inst_req || !last_data);
`else
    assign idle_grant = data_req;
`endif

    always_comb begin
        grant_d = idle_grant;
        case (state)
            LOCK_I:  grant_d = 1'b0;
            LOCK_D:  grant_d = 1'b1;
            default: grant_d = idle_grant;
        endcase
    end

    assign granted_req = grant_d ? data_req : inst_req;
    assign fifo_empty  = (cnt == '0);
    // A response popping this cycle frees the head slot, so a full FIFO can still accept.
    assign fifo_full   = (cnt == FULL_CNT) && !mem_data_ok;

    assign mem_req   = granted_req && !fifo_full;
    assign mem_wr    = grant_d ? data_wr    : inst_wr;
    assign mem_size  = grant_d ? data_size  : inst_size;
    assign mem_wstrb = grant_d ? data_wstrb : inst_wstrb;
    assign mem_addr  = grant_d ? data_addr  : inst_addr;
    assign mem_wdata = grant_d ? data_wdata : inst_wdata;

    assign push         = mem_req && mem_addr_ok;
    assign inst_addr_ok = push && !grant_d;
    assign data_addr_ok = push && grant_d;

    assign pop          = mem_data_ok && !fifo_empty;
    assign head_owner   = owner_mem[rd_ptr];
    assign inst_data_ok = pop && !head_owner;
    assign data_data_ok = pop && head_owner;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign ost_cnt = cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_req && !mem_addr_ok)
                    state_nxt = grant_d ? LOCK_D : LOCK_I;
            end
            LOCK_I: begin
                if (!inst_req || push)
                    state_nxt = IDLE;
            end
            LOCK_D: begin
                if (!data_req || push)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            arb_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
            if (mem_data_ok && fifo_empty)
                arb_err <= 1'b1;
        end
    end

`ifdef SRAM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset)
            last_data <= 1'b0;
        else if (push)
            last_data <= grant_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (push)
            owner_mem[wr_ptr] <= grant_d;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter; honours SRAM_ARB_RR_EN to pick the reference grant policy.
module tb_sram_arbiter;

    localparam int DEPTH = 4;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
    logic [1:0]  inst_size = 0, data_size = 0;
    logic [3:0]  inst_wstrb = 0, data_wstrb = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
    logic        mem_addr_ok = 0, mem_data_ok = 0;
    logic [31:0] mem_rdata = 0;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  ost_cnt;
    logic        arb_err;

    sram_arbiter #(.OST_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .ost_cnt(ost_cnt), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Reference state: owners of accepted-but-unanswered requests, a pending
    // (presented but not yet accepted) requester, last winner and error flag.
    bit          own_q[$];
    int          pending = -1;
    bit          last_won = 0;
    bit          err = 0;
    bit          exp_own[$];
    logic [31:0] exp_rd[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  g;
        bit  greq, busy, hs;
        busy = (own_q.size() == DEPTH) && !mem_data_ok;
        if (pending >= 0)
            g = pending;
        else if (RR && inst_req && data_req)
            g = last_won ? 0 : 1;
        else
            g = data_req ? 1 : 0;
        greq = (g == 1) ? data_req : inst_req;
        hs   = greq && !busy && mem_addr_ok;

        if (chk_en) begin
            check("mem_req", mem_req, greq && !busy);
            check("inst_addr_ok", inst_addr_ok, hs && g == 0);
            check("data_addr_ok", data_addr_ok, hs && g == 1);
            if (g == 1)
                check("mem_fields", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
                      {data_wr, data_size, data_wstrb, data_addr, data_wdata});
            else
                check("mem_fields", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
                      {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata});
            check("ost_cnt", ost_cnt, own_q.size());
            check("arb_err", arb_err, err);
        end

        if (mem_data_ok) begin
            if (own_q.size() > 0) begin
                if (chk_en) begin
                    exp_own.push_back(own_q[0]);
                    exp_rd.push_back(mem_rdata);
                end
                void'(own_q.pop_front());
            end else begin
                err = 1;
            end
        end
        if (hs) begin
            own_q.push_back(g[0]);
            last_won = g[0];
        end
        if (pending >= 0) begin
            if (!greq || hs)
                pending = -1;
        end else if (greq && !busy && !mem_addr_ok) begin
            pending = g;
        end

        if (reset) begin
            own_q.delete();
            pending  = -1;
            last_won = 0;
            err      = 0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // Response monitor: consumes the responses the model expects this cycle.
    initial forever begin
        @(negedge clk);
        #1;
        if (exp_own.size() > 0) begin
            bit          o;
            logic [31:0] rd;
            o  = exp_own.pop_front();
            rd = exp_rd.pop_front();
            check("inst_data_ok", inst_data_ok, !o);
            check("data_data_ok", data_data_ok, o);
            check("rdata", {inst_rdata, data_rdata}, {rd, rd});
        end else if (chk_en) begin
            check("no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        end
    end

    task automatic cyc(input bit rst, input bit ir, input bit dr, input logic [31:0] ia,
                       input logic [31:0] da, input bit aok, input bit dok, input logic [31:0] rd);
        reset       = rst;
        inst_req    = ir;
        data_req    = dr;
        inst_addr   = ia;
        data_addr   = da;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
        inst_wr     = 1'($urandom);
        data_wr     = 1'($urandom);
        inst_size   = 2'($urandom);
        data_size   = 2'($urandom);
        inst_wstrb  = 4'($urandom);
        data_wstrb  = 4'($urandom);
        inst_wdata  = $urandom;
        data_wdata  = $urandom;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // Simultaneous requests: data wins from reset in either policy.
        cyc(0, 1, 1, 32'h1c000000, 32'h00001000, 1, 0, 0);
        // Data waits three cycles, then inst joins while data is locked.
        repeat (3) cyc(0, 0, 1, 32'h1c000004, 32'h00002000, 0, 0, 0);
        cyc(0, 1, 1, 32'h1c000004, 32'h00002000, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, $urandom);
        // Fill the FIFO with fetches, stall, then push and pop together.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 32'h1c000100 + 4*i, 0, 1, 0, 0);
        cyc(0, 1, 0, 32'h1c000200, 0, 1, 0, 0);
        cyc(0, 1, 0, 32'h1c000200, 0, 1, 1, 32'haaaa5555);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 1, $urandom);
        // Interleaved owners must be answered in issue order.
        cyc(0, 1, 0, 32'h1c000300, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 32'h00003000, 1, 0, 0);
        cyc(0, 1, 0, 32'h1c000304, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h11);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h22);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h33);
        // Stray response with nothing outstanding sets the sticky error.
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h44);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // Both requesting with accept every cycle: alternation under round-robin.
        cyc(0, 1, 1, 32'h1c000400, 32'h00004000, 1, 0, 0);
        repeat (6) cyc(0, 1, 1, 32'h1c000400, 32'h00004000, 1, 1, $urandom);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, $urandom);
        // Random traffic with occasional stray responses and mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            bit dok;
            if (own_q.size() > 0) dok = ($urandom_range(0, 1) == 1);
            else                  dok = ($urandom_range(0, 49) == 0);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom, $urandom, $urandom_range(0, 4) < 3, dok, $urandom);
        end
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
